maj3_ctrl_loader: RTL



---
 rtl/maj3_pkg.sv | 14 +
 rtl/maj3_ctrl_loader.sv | 107 ++++++++++
 2 files changed

// File: rtl/maj3_pkg.sv
// Shared types and helpers for the maj3_gate control path (loader and array wrapper).
package maj3_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT
  } state_t;

  function automatic int num_words(input int gates, input int w);
    return (gates + w - 1) / w;
  endfunction

endpackage

// File: rtl/maj3_ctrl_loader.sv
// Assembles streamed control words into a shadow register and commits the full
// configuration to the maj3_gate layer in a single edge.
module maj3_ctrl_loader
  import maj3_pkg::*;
#(
  parameter int NUM_GATES = 64,
  parameter int WORD_W    = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic                 abort_in,
  input  logic [WORD_W-1:0]    word_in,
  input  logic                 word_valid_in,
  output logic                 word_ready_out,
  output logic [NUM_GATES-1:0] control_out,
  output logic                 busy_out,
  output logic                 done_out
);

  localparam int NUM_WORDS = num_words(NUM_GATES, WORD_W);
  localparam int CNT_W     = $clog2(NUM_WORDS + 1);

  state_t               state_q;
  state_t               state_d;
  logic [CNT_W-1:0]     counter;
  logic [NUM_GATES-1:0] shadow;
  logic                 handshake;
  logic                 last_word;
  logic                 commit_now;

  assign handshake  = word_valid_in && word_ready_out;
  assign last_word  = (counter == CNT_W'(NUM_WORDS - 1));
  assign commit_now = (state_q == COMMIT) && !abort_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    word_ready_out = 1'b0;
    busy_out       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        word_ready_out = 1'b1;
        busy_out       = 1'b1;
        // abort has priority over completing the final word
        if (abort_in) begin
          state_d = IDLE;
        end else if (handshake && last_word) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        busy_out = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      counter <= '0;
    end else if ((state_q == IDLE) && start_in) begin
      counter <= '0;
    end else if (handshake) begin
      counter <= counter + 1'b1;
    end
  end

  // Each gate bit is owned by exactly one word slot; padding bits of the last word have no home.
  for (genvar g = 0; g < NUM_GATES; g++) begin : g_shadow
    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        shadow[g] <= 1'b0;
      end else if (handshake && (counter == CNT_W'(g / WORD_W))) begin
        shadow[g] <= word_in[g % WORD_W];
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      control_out <= '0;
      done_out    <= 1'b0;
    end else begin
      done_out <= commit_now;
      if (commit_now) begin
        control_out <= shadow;
      end
    end
  end

endmodule
